branch_eval_serial: RTL and testbench
=====================================

// Module: branch_eval_serial
// PURPOSE
//   Multicycle branch resolver for the multiciclo core. It consumes rs1/rs2, funct3, PC
//   and the sign-extended B-immediate, and returns the branch decision and the next PC.
//   It compares the operands serially, MSB-first, CHUNK bits per cycle, and exits early
//   on the first differing chunk. It sits between the register-read stage and the PC
//   update of the control FSM, and performs the branch decision the flat comparator
//   does not provide.
// PARAMETERS
//   XLEN   32  operand/PC width
//   CHUNK  8   bits compared per cycle; XLEN % CHUNK must be 0 (elaboration $error otherwise)
// PORTS
//   clk      in   1     single clock, rising edge
//   rst      in   1     reset, asynchronous, active-high
//   start    in   1     request; sampled in IDLE or DONE only
//   funct3   in   3     RV32I branch funct3 (000 BEQ,001 BNE,100 BLT,101 BGE,110 BLTU,111 BGEU)
//   rs1      in   XLEN  operand A
//   rs2      in   XLEN  operand B
//   pc       in   XLEN  PC of branch instruction
//   imm      in   XLEN  sign-extended branch offset
//   busy     out  1     high in CMP state
//   done     out  1     one-cycle pulse, result valid
//   taken    out  1     branch taken
//   pc_next  out  XLEN  pc+imm if taken else pc+4
//   illegal  out  1     funct3 is 010 or 011
// BEHAVIOUR
//   Reset (async, any state): state=IDLE. busy, done, taken and illegal all =0; pc_next=0.
//   States: IDLE, CMP, DONE.
//   IDLE/DONE + start: latch funct3, pc, imm.
//     Signed ops (BLT/BGE): latch rs1^MSB_MASK and rs2^MSB_MASK.
//     All other ops: latch rs1 and rs2 unchanged.
//     Clear chunk index k=0.
//     Legal funct3 -> CMP. Illegal funct3 -> DONE with illegal=1, taken=0.
//   IDLE/DONE, no start -> IDLE. done is high only in the DONE cycle.
//   CMP, each cycle: compare chunk k (bits XLEN-1-k*CHUNK downto XLEN-(k+1)*CHUNK).
//     Chunks differ: lt=(a_chunk<b_chunk), eq=0 -> DONE.
//     Chunks equal, last chunk: eq=1, lt=0 -> DONE.
//     Otherwise: k++.
//   taken in DONE: BEQ=eq, BNE=!eq, BLT/BLTU=lt, BGE/BGEU=!lt.
//   pc_next = taken ? pc+imm : pc+4. Both sums are modulo 2^XLEN (wrap, no flag).
//   taken, pc_next and illegal are registered on entry to DONE. They hold until the next
//     accepted start, and are cleared only by reset.
//   Latency: start at cycle 0; difference found at chunk j (0-based) -> done at cycle j+2.
//     Equal operands: done at cycle XLEN/CHUNK+1 (5 with defaults). Illegal: done at cycle 1.
//   start while busy: ignored, latched operands unchanged.
//   start in the DONE cycle: accepted (back-to-back issue).
//   Input changes after acceptance have no effect.
//   Reset mid-CMP aborts; no done is produced.
// TESTING
//   1 BEQ rs1=rs2=0x12345678, pc=0x100, imm=0x20 -> done @cycle5, taken=1, pc_next=0x120
//   2 BLT rs1=0xFFFFFFFF, rs2=0x1, pc=0x200, imm=0xFFFFFFF0 -> done @cycle2, taken=1,
//     pc_next=0x1F0. BLTU, same operands -> done @cycle2, taken=0, pc_next=0x204
//   3 BNE rs1=0x1, rs2=0x0 -> done @cycle5, taken=1.
//     BGE rs1=0x80000000, rs2=0x7FFFFFFF -> done @cycle2, taken=0
//   4 funct3=010 -> done @cycle1, illegal=1, taken=0, pc_next=pc+4, busy never set
//   5 rst pulsed during CMP cycle 2 -> all outputs 0 asynchronously, no done.
//     Next BEQ completes normally
//   6 start held during CMP, then start in DONE cycle with new BNE -> first result
//     unaffected, second accepted, done 5 cycles later.
//     pc=0xFFFFFFFC, imm=0x8, taken -> pc_next=0x4

Source files
------------

// File: rtl/branch_eval_serial.sv
// Serial RV32I branch resolver: compares rs1/rs2 MSB-first, CHUNK bits per cycle,
// exits on the first differing chunk and returns taken/pc_next with a one-cycle done.
module branch_eval_serial #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            busy,
  output logic            done,
  output logic            taken,
  output logic [XLEN-1:0] pc_next,
  output logic            illegal
);

  localparam int unsigned NumChunks = XLEN / CHUNK;
  localparam int unsigned KW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [XLEN-1:0] MsbMask = {1'b1, {(XLEN-1){1'b0}}};

  if (XLEN % CHUNK != 0) begin : g_bad_chunk
    $error("branch_eval_serial: XLEN must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [KW-1:0]   k_q, k_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] pc_next_q, pc_next_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             finish, cmp_eq, cmp_lt, take;
  logic             is_signed, is_illegal;

  // Operands are shifted left each cycle so the current chunk is always the top one.
  assign a_chunk    = a_q[XLEN-1 -: CHUNK];
  assign b_chunk    = b_q[XLEN-1 -: CHUNK];
  assign is_signed  = (funct3 == 3'b100) || (funct3 == 3'b101);
  assign is_illegal = (funct3[2:1] == 2'b01);

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    a_d       = a_q;
    b_d       = b_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    k_d       = k_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    pc_next_d = pc_next_q;
    finish    = 1'b0;
    cmp_eq    = 1'b0;
    cmp_lt    = 1'b0;
    take      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          f3_d  = funct3;
          pc_d  = pc;
          imm_d = imm;
          // Flipping the sign bit turns a signed compare into an unsigned one.
          a_d   = is_signed ? (rs1 ^ MsbMask) : rs1;
          b_d   = is_signed ? (rs2 ^ MsbMask) : rs2;
          k_d   = '0;
          if (is_illegal) begin
            state_d   = StDone;
            illegal_d = 1'b1;
            taken_d   = 1'b0;
            pc_next_d = pc + XLEN'(4);
          end else begin
            state_d = StCmp;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCmp: begin
        if (a_chunk != b_chunk) begin
          finish = 1'b1;
          cmp_lt = (a_chunk < b_chunk);
        end else if (k_q == KW'(NumChunks - 1)) begin
          finish = 1'b1;
          cmp_eq = 1'b1;
        end else begin
          k_d = k_q + KW'(1);
          a_d = a_q << CHUNK;
          b_d = b_q << CHUNK;
        end
        if (finish) begin
          unique case (f3_q)
            3'b000:         take = cmp_eq;
            3'b001:         take = !cmp_eq;
            3'b100, 3'b110: take = cmp_lt;
            3'b101, 3'b111: take = !cmp_lt;
            default:        take = 1'b0;
          endcase
          state_d   = StDone;
          taken_d   = take;
          illegal_d = 1'b0;
          pc_next_d = take ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      k_q       <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      pc_next_q <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      k_q       <= k_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      pc_next_q <= pc_next_d;
    end
  end

  assign busy    = (state_q == StCmp);
  assign done    = (state_q == StDone);
  assign taken   = taken_q;
  assign illegal = illegal_q;
  assign pc_next = pc_next_q;

endmodule

// File: tb/tb_branch_eval_serial.sv
// Directed bench for branch_eval_serial: latency, decision, next-PC, illegal, reset abort,
// and back-to-back issue, checked with immediate assertions.
module tb_branch_eval_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm;
  logic        busy, done, taken, illegal;
  logic [31:0] pc_next;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  logic busy_seen;
  int   done_seen;

  branch_eval_serial #(.XLEN(32), .CHUNK(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1     (rs1),
    .rs2     (rs2),
    .pc      (pc),
    .imm     (imm),
    .busy    (busy),
    .done    (done),
    .taken   (taken),
    .pc_next (pc_next),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; start is high for the cycle that follows (cycle 0).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i);
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    pc     = p;
    imm    = i;
    start  = 1'b1;
  endtask

  // Returns the cycle index (relative to the issue cycle) at which done is seen.
  task automatic wait_done(output int c, output logic bs);
    c  = 0;
    bs = 1'b0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      c++;
      if (busy) bs = 1'b1;
    end while (!done && c < 20);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    rs1    = '0;
    rs2    = '0;
    pc     = '0;
    imm    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_taken", taken, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc_next", pc_next, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: BEQ equal operands, full scan
    issue(3'b000, 32'h12345678, 32'h12345678, 32'h100, 32'h20);
    wait_done(cyc, busy_seen);
    check("beq_latency", cyc, 5);
    check("beq_taken", taken, 1);
    check("beq_pc_next", pc_next, 32'h120);
    @(posedge clk);
    #1;
    check("beq_done_pulse", done, 0);
    check("beq_hold_taken", taken, 1);
    check("beq_hold_pc", pc_next, 32'h120);

    // 2: BLT vs BLTU on the same operands
    issue(3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0);
    wait_done(cyc, busy_seen);
    check("blt_latency", cyc, 2);
    check("blt_taken", taken, 1);
    check("blt_pc_next", pc_next, 32'h1F0);
    @(posedge clk);
    #1;
    issue(3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0);
    wait_done(cyc, busy_seen);
    check("bltu_latency", cyc, 2);
    check("bltu_taken", taken, 0);
    check("bltu_pc_next", pc_next, 32'h204);
    @(posedge clk);
    #1;

    // 3: BNE differing in the last chunk, BGE signed boundary
    issue(3'b001, 32'h1, 32'h0, 32'h400, 32'h10);
    wait_done(cyc, busy_seen);
    check("bne_latency", cyc, 5);
    check("bne_taken", taken, 1);
    check("bne_pc_next", pc_next, 32'h410);
    @(posedge clk);
    #1;
    issue(3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h500, 32'h40);
    wait_done(cyc, busy_seen);
    check("bge_latency", cyc, 2);
    check("bge_taken", taken, 0);
    check("bge_pc_next", pc_next, 32'h504);
    @(posedge clk);
    #1;

    // 4: illegal funct3
    issue(3'b010, 32'h5, 32'h5, 32'h600, 32'h80);
    wait_done(cyc, busy_seen);
    check("ill_latency", cyc, 1);
    check("ill_flag", illegal, 1);
    check("ill_taken", taken, 0);
    check("ill_pc_next", pc_next, 32'h604);
    check("ill_no_busy", busy_seen, 0);
    @(posedge clk);
    #1;

    // 5: reset in the middle of a compare
    issue(3'b000, 32'h5, 32'h5, 32'h300, 32'h40);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_taken", taken, 0);
    check("abort_illegal", illegal, 0);
    check("abort_pc_next", pc_next, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    issue(3'b000, 32'h5, 32'h5, 32'h300, 32'h40);
    wait_done(cyc, busy_seen);
    check("post_rst_latency", cyc, 5);
    check("post_rst_taken", taken, 1);
    check("post_rst_pc_next", pc_next, 32'h340);
    @(posedge clk);
    #1;

    // 6: start held through CMP is ignored; start in the DONE cycle is accepted
    issue(3'b000, 32'hAAAA5555, 32'hAAAA5555, 32'h700, 32'h30);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check("held_busy", busy, 1);
      funct3 = 3'b001;
      rs1    = 32'h0;
      rs2    = 32'h5;
      pc     = 32'h0;
      imm    = 32'h0;
    end
    @(posedge clk);
    #1;
    check("held_done", done, 1);
    check("held_taken", taken, 1);
    check("held_pc_next", pc_next, 32'h730);
    issue(3'b001, 32'h1, 32'h0, 32'hFFFFFFFC, 32'h8);
    wait_done(cyc, busy_seen);
    check("b2b_latency", cyc, 5);
    check("b2b_taken", taken, 1);
    check("b2b_pc_wrap", pc_next, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
